oflow_status_reporter: RTL and testbench

Readout-side counterpart to the per-channel sticky overflow detectors. On request it snapshots all channel overflow flags and sends them as a framed byte stream over a valid/ready byte interface to the readout path. Once the last byte is accepted, it issues a one-cycle clear pulse only to the channels it reported. It sits between the ADC-channel overflow detectors and the readout/UART byte mux.

---
 rtl/oflow_pkg.sv | 18 +
 rtl/oflow_status_reporter.sv | 126 ++++++++++++
 tb/tb_oflow_status_reporter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/oflow_pkg.sv
// Shared definitions for the overflow status reporter: header byte,
// frame sizing helper and the reporter FSM state encoding.
package oflow_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'h4F;

  // Number of data bytes needed to carry n channel flags.
  function automatic int nb(input int n);
    return (n + 7) / 8;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/oflow_status_reporter.sv
// Snapshots the sticky overflow flags on request, streams them out as
// HDR, D0..D(NB-1), CHK over a valid/ready byte port, then pulses a clear
// back to exactly the channels that were reported.
module oflow_status_reporter
  import oflow_pkg::*;
#(
  parameter int         N_CH = 9,
  parameter logic [7:0] HDR  = HDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] oflow_state,
  input  logic            rd_req,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic [N_CH-1:0] oflow_Clr,
  output logic            busy,
  output logic            oflow_any
);

  localparam int NB    = nb(N_CH);
  localparam int IDX_W = $clog2(NB + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]   snap_q, snap_d;
  logic              pend_q, pend_d;
  logic              oflow_any_q, oflow_any_d;

  logic [NB*8-1:0]   snap_pad;
  logic [7:0]        chk;
  logic [7:0]        byte_sel;

  // Zero-pad the snapshot to whole bytes and fold the data bytes into CHK.
  always_comb begin
    snap_pad = '0;
    snap_pad[N_CH-1:0] = snap_q;
    chk = 8'h00;
    for (int i = 0; i < NB; i++) begin
      chk = chk ^ snap_pad[i*8 +: 8];
    end
  end

  // Pick the byte addressed by idx: header, data bytes, then checksum.
  always_comb begin
    byte_sel = HDR;
    if (idx_q == LAST_IDX) begin
      byte_sel = chk;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (idx_q == IDX_W'(i + 1)) begin
          byte_sel = snap_pad[i*8 +: 8];
        end
      end
    end
  end

  // Next-state logic: frame sequencing plus the one-deep pending request.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    pend_d      = pend_q;
    oflow_any_d = |oflow_state;
    case (state_q)
      IDLE: begin
        if (rd_req || pend_q) begin
          snap_d  = oflow_state;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rd_req) begin
          pend_d = 1'b1;
        end
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = CLEAR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        if (rd_req) begin
          pend_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset never produces a clear pulse since snap and state are zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      pend_q      <= 1'b0;
      oflow_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      pend_q      <= pend_d;
      oflow_any_q <= oflow_any_d;
    end
  end

  // Outputs decode from registered state, so tx_data/tx_valid hold until accepted.
  always_comb begin
    tx_valid  = (state_q == SEND);
    tx_data   = (state_q == SEND) ? byte_sel : 8'h00;
    oflow_Clr = (state_q == CLEAR) ? snap_q : '0;
    busy      = (state_q != IDLE) || pend_q;
    oflow_any = oflow_any_q;
  end

endmodule

// File: tb/tb_oflow_status_reporter.sv
// Directed bench for oflow_status_reporter with a simple sticky-detector
// model feeding oflow_state and consuming oflow_Clr.
module tb_oflow_status_reporter;

  logic       clk;
  logic       rst_n;
  logic [8:0] oflow_state;
  logic       rd_req;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [8:0] oflow_Clr;
  logic       busy;
  logic       oflow_any;

  logic [8:0] det;
  logic [8:0] set_mask;
  logic       det_wipe;

  int checks = 0;
  int errors = 0;

  oflow_status_reporter #(.N_CH(9), .HDR(8'h4F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .oflow_state(oflow_state),
    .rd_req     (rd_req),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .oflow_Clr  (oflow_Clr),
    .busy       (busy),
    .oflow_any  (oflow_any)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sticky detector model: sets from set_mask, clears on the edge that samples oflow_Clr
  always @(posedge clk) begin
    if (det_wipe) det <= '0;
    else          det <= (det & ~oflow_Clr) | set_mask;
  end
  assign oflow_state = det;

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic ready, input logic [8:0] setm);
    rd_req   = req;
    tx_ready = ready;
    set_mask = setm;
  endtask

  // Walks one frame from the negedge after the snapshot edge through the CLEAR cycle.
  // readyPat bit c drives tx_ready in loop cycle c; reqMask bit c raises rd_req in loop
  // cycle c and bit 16 raises it during the CLEAR cycle.
  task automatic expectFrame(input string tag, input logic [31:0] frame, input logic [8:0] clr,
                             input logic [15:0] readyPat, input logic [16:0] reqMask);
    int j = 0;
    int c = 0;
    while (j < 4 && c < 16) begin
      checkOutput({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
      checkOutput({tag, " data"}, {24'd0, tx_data}, {24'd0, frame[31-8*j -: 8]});
      checkOutput({tag, " clr_idle"}, {23'd0, oflow_Clr}, 32'd0);
      tx_ready = readyPat[c];
      rd_req   = reqMask[c];
      cycle();
      if (readyPat[c]) j++;
      c++;
    end
    if (j < 4) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    tx_ready = 1'b0;
    rd_req   = reqMask[16];
    checkOutput({tag, " clr"}, {23'd0, oflow_Clr}, {23'd0, clr});
    checkOutput({tag, " busy_clear"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, " valid_clear"}, {31'd0, tx_valid}, 32'd0);
    cycle();
    rd_req = 1'b0;
    checkOutput({tag, " clr_end"}, {23'd0, oflow_Clr}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    det_wipe = 1'b1;
    applyStimulus(1'b0, 1'b0, 9'h000);
    cycle();
    cycle();

    // Reset state
    checkOutput("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst clr", {23'd0, oflow_Clr}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst any", {31'd0, oflow_any}, 32'd0);
    rst_n    = 1'b1;
    det_wipe = 1'b0;
    cycle();

    // Basic frame with flags 9'h105 and oflow_any latency
    applyStimulus(1'b0, 1'b0, 9'h105);
    cycle();
    applyStimulus(1'b0, 1'b0, 9'h000);
    checkOutput("any latency0", {31'd0, oflow_any}, 32'd0);
    cycle();
    checkOutput("any latency1", {31'd0, oflow_any}, 32'd1);
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 1'b1, 9'h000);
    cycle();
    rd_req = 1'b0;
    checkOutput("basic busy", {31'd0, busy}, 32'd1);
    expectFrame("basic", 32'h4F050104, 9'h105, 16'hFFFF, 17'h0);
    checkOutput("basic busy_end", {31'd0, busy}, 32'd0);
    checkOutput("basic any_hold", {31'd0, oflow_any}, 32'd1);
    cycle();
    checkOutput("basic any_drop", {31'd0, oflow_any}, 32'd0);

    // Backpressure: tx_ready 1-0-0-1 repeating
    applyStimulus(1'b0, 1'b0, 9'h105);
    cycle();
    applyStimulus(1'b1, 1'b0, 9'h000);
    cycle();
    rd_req = 1'b0;
    expectFrame("bp", 32'h4F050104, 9'h105, 16'b1001100110011001, 17'h0);
    cycle();

    // Race: snapshot 9'h001, channel 3 rises during SEND
    applyStimulus(1'b0, 1'b0, 9'h001);
    cycle();
    applyStimulus(1'b1, 1'b0, 9'h000);
    cycle();
    applyStimulus(1'b0, 1'b0, 9'h008);
    expectFrame("race", 32'h4F010001, 9'h001, 16'hFFFF, 17'h0);
    set_mask = 9'h000;
    rd_req   = 1'b1;
    cycle();
    rd_req = 1'b0;
    expectFrame("race2", 32'h4F080008, 9'h008, 16'hFFFF, 17'h0);
    cycle();

    // Queueing: requests in SEND (second one dropped) and in CLEAR -> one extra frame
    applyStimulus(1'b0, 1'b0, 9'h0F0);
    cycle();
    applyStimulus(1'b1, 1'b0, 9'h000);
    cycle();
    rd_req = 1'b0;
    expectFrame("queue", 32'h4FF000F0, 9'h0F0, 16'hFFFF, 17'h10006);
    checkOutput("queue pend_busy", {31'd0, busy}, 32'd1);
    checkOutput("queue gap_valid", {31'd0, tx_valid}, 32'd0);
    cycle();
    expectFrame("queue2", 32'h4F000000, 9'h000, 16'hFFFF, 17'h0);
    checkOutput("queue2 busy_end", {31'd0, busy}, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("queue no_third", {31'd0, tx_valid}, 32'd0);
    end
    tx_ready = 1'b0;

    // Reset mid-frame after header accepted
    applyStimulus(1'b0, 1'b0, 9'h003);
    cycle();
    applyStimulus(1'b1, 1'b1, 9'h000);
    cycle();
    rd_req = 1'b0;
    cycle();
    checkOutput("mid data", {24'd0, tx_data}, 32'h03);
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("mid rst_clr", {23'd0, oflow_Clr}, 32'd0);
    checkOutput("mid rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid rst_any", {31'd0, oflow_any}, 32'd0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("mid no_clr", {23'd0, oflow_Clr}, 32'd0);
      checkOutput("mid no_valid", {31'd0, tx_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 9'h000);
    cycle();
    rd_req = 1'b0;
    expectFrame("fresh", 32'h4F030003, 9'h003, 16'hFFFF, 17'h0);
    cycle();

    // Zero flags
    checkOutput("zero any_pre", {31'd0, oflow_any}, 32'd0);
    applyStimulus(1'b1, 1'b0, 9'h000);
    cycle();
    rd_req = 1'b0;
    expectFrame("zero", 32'h4F000000, 9'h000, 16'hFFFF, 17'h0);
    checkOutput("zero any_post", {31'd0, oflow_any}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
